// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Converts the CPU M-stage single-cycle data access into an SRAM-like
//   req/addr_ok/data_ok bus transaction. The pipeline is stalled while a
//   transaction is outstanding. A flush during a transaction marks its result
//   for discard; the bus transaction still runs to completion.
//
//   Optional build macro: DSRAM_ADDR_MAP_EN
//     When it is defined, kseg0/kseg1 addresses (top bits 3'b100 / 3'b101) are
//     mapped to physical addresses by clearing the top three bits.
//     When it is undefined, the address passes through unchanged.
//
// Ports
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   memenM, memwriteM     M-stage access enable and byte write enables (0000 = read)
//   aluoutM, writedataM   effective address and lane-aligned store data
//   flushM                M stage is being flushed
//   readdataM             registered load data returned to the core
//   stallM                combinational pipeline freeze
//   data_req/wr/size/addr/wdata   bus request side
//   data_addr_ok/data_ok/rdata    bus response side

module data_sram_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memenM,
    input  logic [3:0]        memwriteM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              flushM,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_t;

    state_t            stateQ, stateD;
    logic              discardQ, discardD;
    logic [DATA_W-1:0] readdataQ, readdataD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] wdataQ, wdataD;
    logic              wrQ, wrD;
    logic [1:0]        sizeQ, sizeD;
    logic              reqComb;
    logic              stallComb;

    // Transfer size from the byte-enable pattern; irregular patterns fall back to word.
    function automatic logic [1:0] sizeOf(input logic [3:0] be);
        logic [1:0] sz;
        case (be)
            4'b1111, 4'b0000:                   sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic [ADDR_W-1:0] mapAddr(input logic [ADDR_W-1:0] va);
        logic [ADDR_W-1:0] pa;
        pa = va;
`ifdef DSRAM_ADDR_MAP_EN
        // kseg0 (100) and kseg1 (101) are unmapped windows onto physical memory.
        if (va[ADDR_W-1 -: 3] == 3'b100 || va[ADDR_W-1 -: 3] == 3'b101) begin
            pa[ADDR_W-1 -: 3] = 3'b000;
        end
`endif
        return pa;
    endfunction

    always_comb begin
        stateD    = stateQ;
        discardD  = discardQ;
        readdataD = readdataQ;
        addrD     = addrQ;
        wdataD    = wdataQ;
        wrD       = wrQ;
        sizeD     = sizeQ;
        reqComb   = 1'b0;
        stallComb = 1'b0;

        case (stateQ)
            StIdle: begin
                if (memenM && !flushM) begin
                    stallComb = 1'b1;
                    addrD     = mapAddr(aluoutM);
                    wdataD    = writedataM;
                    wrD       = |memwriteM;
                    sizeD     = sizeOf(memwriteM);
                    discardD  = 1'b0;
                    stateD    = StReq;
                end
            end
            StReq: begin
                reqComb   = 1'b1;
                stallComb = 1'b1;
                if (flushM) begin
                    discardD = 1'b1;
                end
                if (data_addr_ok) begin
                    stateD = StWait;
                end
            end
            StWait: begin
                stallComb = 1'b1;
                if (flushM) begin
                    discardD = 1'b1;
                end
                if (data_data_ok) begin
                    // A flush arriving together with data_ok also kills the result.
                    if (discardQ || flushM) begin
                        discardD = 1'b0;
                        stateD   = StIdle;
                    end else begin
                        if (!wrQ) begin
                            readdataD = data_rdata;
                        end
                        stateD = StDone;
                    end
                end
            end
            StDone: begin
                // One cycle with the stall released so the M instruction retires.
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            discardQ  <= 1'b0;
            readdataQ <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            wrQ       <= 1'b0;
            sizeQ     <= 2'd0;
        end else begin
            stateQ    <= stateD;
            discardQ  <= discardD;
            readdataQ <= readdataD;
            addrQ     <= addrD;
            wdataQ    <= wdataD;
            wrQ       <= wrD;
            sizeQ     <= sizeD;
        end
    end

    assign readdataM  = readdataQ;
    assign stallM     = stallComb;
    assign data_req   = reqComb;
    assign data_wr    = wrQ;
    assign data_size  = sizeQ;
    assign data_addr  = addrQ;
    assign data_wdata = wdataQ;

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge
//   Directed bench for data_sram_bridge. A per-cycle vector table drives the
//   core and slave inputs and lists the expected bus/stall/readdata outputs;
//   a few hand-written sequences cover long slave delays, size decoding and
//   address mapping.

module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        memenM;
    logic [3:0]  memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    data_sram_bridge #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memenM      (memenM),
        .memwriteM   (memwriteM),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .flushM      (flushM),
        .readdataM   (readdataM),
        .stallM      (stallM),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        memen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        expReq;
        logic        expStall;
        logic [31:0] expRd;
        logic        chkBus;
        logic        expWr;
        logic [1:0]  expSize;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic addV(input logic r, input logic me, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, input logic fl,
                        input logic aok, input logic dok, input logic [31:0] rd,
                        input logic eReq, input logic eStall, input logic [31:0] eRd,
                        input logic cb, input logic eWr, input logic [1:0] eSz,
                        input logic [31:0] eAddr, input logic [31:0] eWd);
        vec_t v;
        v.rst = r; v.memen = me; v.be = be; v.addr = a; v.wdata = wd; v.flush = fl;
        v.aok = aok; v.dok = dok; v.rdata = rd;
        v.expReq = eReq; v.expStall = eStall; v.expRd = eRd;
        v.chkBus = cb; v.expWr = eWr; v.expSize = eSz; v.expAddr = eAddr; v.expWdata = eWd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic me, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, input logic fl, input logic aok,
                         input logic dok, input logic [31:0] rd);
        memenM = me; memwriteM = be; aluoutM = a; writedataM = wd; flushM = fl;
        data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
    endtask

    function automatic logic [31:0] expMap(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
`ifdef DSRAM_ADDR_MAP_EN
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) pa = {3'b000, va[28:0]};
`endif
        return pa;
    endfunction

    // Zero-wait transaction checking the request fields on the bus.
    task automatic txn(input int idx, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] eSz);
        setIn(1'b1, be, a, wd, 1'b0, 1'b0, 1'b0, 32'h0);
        #4 chk("txn_idle_stall", idx, 32'(stallM), 32'd1);
        tick();
        data_addr_ok = 1'b1;
        #4;
        chk("txn_req", idx, 32'(data_req), 32'd1);
        chk("txn_size", idx, 32'(data_size), 32'(eSz));
        chk("txn_wr", idx, 32'(data_wr), 32'(|be));
        chk("txn_addr", idx, data_addr, expMap(a));
        chk("txn_wdata", idx, data_wdata, wd);
        tick();
        setIn(1'b1, be, a, wd, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        setIn(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #4 chk("txn_done_stall", idx, 32'(stallM), 32'd0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        setIn(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        //    rst me be       addr          wdata         fl aok dok rdata
        //    req stall rd           chkBus wr sz addr  wdata
        // Reset state.
        addV(1, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'h0, 1, 0, 2'd0, 32'h0, 32'h0);
        // Zero-wait read of 0x100 returning DEADBEEF.
        addV(0, 1, 4'b0000, 32'h100, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h100, 32'h0, 0, 1, 0, 32'h0,
             1, 1, 32'h0, 1, 0, 2'd2, 32'h100, 32'h0);
        addV(0, 1, 4'b0000, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h100, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        // Byte store to 0x202; readdata must not change.
        addV(0, 1, 4'b0100, 32'h202, 32'h00AB0000, 0, 0, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0100, 32'h202, 32'h00AB0000, 0, 1, 0, 32'h0,
             1, 1, 32'hDEADBEEF, 1, 1, 2'd0, 32'h202, 32'h00AB0000);
        addV(0, 1, 4'b0100, 32'h202, 32'h00AB0000, 0, 0, 1, 32'h55555555,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0100, 32'h202, 32'h00AB0000, 0, 0, 0, 32'h0,
             0, 0, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        // Back-to-back half store, addr_ok delayed two cycles, data_ok one.
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 0, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 0, 1, 32'h0,
             1, 1, 32'hDEADBEEF, 1, 1, 2'd1, 32'h300, 32'h0000CAFE);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 0, 0, 32'h0,
             1, 1, 32'hDEADBEEF, 1, 1, 2'd1, 32'h300, 32'h0000CAFE);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 1, 0, 32'h0,
             1, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 1, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 0, 1, 32'h77777777,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0011, 32'h300, 32'h0000CAFE, 0, 0, 0, 32'h0,
             0, 0, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        // Flush while in WAIT: result discarded, no DONE cycle.
        addV(0, 1, 4'b0000, 32'h400, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h400, 32'h0, 0, 1, 0, 32'h0,
             1, 1, 32'hDEADBEEF, 1, 0, 2'd2, 32'h400, 32'h0);
        addV(0, 1, 4'b0000, 32'h400, 32'h0, 1, 0, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 32'h12345678,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        // Back in IDLE (a DONE here would show stall low).
        addV(0, 1, 4'b0000, 32'h500, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h500, 32'h0, 0, 1, 0, 32'h0,
             1, 1, 32'hDEADBEEF, 1, 0, 2'd2, 32'h500, 32'h0);
        addV(0, 1, 4'b0000, 32'h500, 32'h0, 0, 0, 1, 32'h0BADF00D,
             0, 1, 32'hDEADBEEF, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'h0BADF00D, 0, 0, 2'd0, 32'h0, 32'h0);
        // Flush in IDLE: no request.
        addV(0, 1, 4'b0000, 32'h580, 32'h0, 1, 0, 0, 32'h0,
             0, 0, 32'h0BADF00D, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 0, 32'h0,
             0, 0, 32'h0BADF00D, 1, 0, 2'd2, 32'h500, 32'h0);
        // Reset while in REQ.
        addV(0, 1, 4'b0000, 32'h600, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'h0BADF00D, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(1, 1, 4'b0000, 32'h600, 32'h0, 0, 0, 0, 32'h0,
             1, 1, 32'h0BADF00D, 1, 0, 2'd2, 32'h600, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'h0, 1, 0, 2'd0, 32'h0, 32'h0);
        // Flush in REQ, then a normal read that ends with a flush in DONE.
        addV(0, 1, 4'b0000, 32'h700, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h700, 32'h0, 1, 0, 0, 32'h0,
             1, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 0, 32'h0,
             1, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 32'hFFFF0000,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h800, 32'h0, 0, 0, 0, 32'h0,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h800, 32'h0, 0, 1, 0, 32'h0,
             1, 1, 32'h0, 1, 0, 2'd2, 32'h800, 32'h0);
        addV(0, 1, 4'b0000, 32'h800, 32'h0, 0, 0, 1, 32'h11223344,
             0, 1, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 1, 4'b0000, 32'h800, 32'h0, 1, 0, 0, 32'h0,
             0, 0, 32'h11223344, 0, 0, 2'd0, 32'h0, 32'h0);
        // Stray data_ok in IDLE is ignored.
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 32'h99999999,
             0, 0, 32'h11223344, 0, 0, 2'd0, 32'h0, 32'h0);
        addV(0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0,
             0, 0, 32'h11223344, 0, 0, 2'd0, 32'h0, 32'h0);

        tick();
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            setIn(vecs[i].memen, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].flush,
                  vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            #4;
            chk("data_req", i, 32'(data_req), 32'(vecs[i].expReq));
            chk("stallM", i, 32'(stallM), 32'(vecs[i].expStall));
            chk("readdataM", i, readdataM, vecs[i].expRd);
            if (vecs[i].chkBus) begin
                chk("data_wr", i, 32'(data_wr), 32'(vecs[i].expWr));
                chk("data_size", i, 32'(data_size), 32'(vecs[i].expSize));
                chk("data_addr", i, data_addr, vecs[i].expAddr);
                chk("data_wdata", i, data_wdata, vecs[i].expWdata);
            end
            tick();
        end
        rst = 1'b0;

        // Slave delays addr_ok by three cycles and data_ok by two more.
        setIn(1'b1, 4'b0000, 32'h900, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            data_addr_ok = (k == 3);
            #4;
            chk("slow_req", 100 + k, 32'(data_req), 32'd1);
            chk("slow_req_addr", 100 + k, data_addr, 32'h900);
            chk("slow_req_stall", 100 + k, 32'(stallM), 32'd1);
            tick();
        end
        data_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_data_ok = (k == 2);
            data_rdata   = 32'hA5A5A5A5;
            #4;
            chk("slow_wait_req", 110 + k, 32'(data_req), 32'd0);
            chk("slow_wait_stall", 110 + k, 32'(stallM), 32'd1);
            tick();
        end
        data_data_ok = 1'b0;
        #4;
        chk("slow_done_stall", 120, 32'(stallM), 32'd0);
        chk("slow_done_rd", 120, readdataM, 32'hA5A5A5A5);
        tick();
        // Exactly one DONE: the next cycle is IDLE and a new access stalls at once.
        setIn(1'b1, 4'b1111, 32'hA00, 32'h01020304, 1'b0, 1'b0, 1'b0, 32'h0);
        #4 chk("slow_after_done", 121, 32'(stallM), 32'd1);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        setIn(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #4 chk("store_keeps_rd", 122, readdataM, 32'hA5A5A5A5);
        tick();

        // Size decoding and address mapping.
        txn(200, 4'b1000, 32'h0000_0013, 32'hAA000000, 2'd0);
        txn(201, 4'b0001, 32'h0000_0010, 32'h000000BB, 2'd0);
        txn(202, 4'b1100, 32'h0000_0022, 32'hCCDD0000, 2'd1);
        txn(203, 4'b0110, 32'h0000_0030, 32'h00EEFF00, 2'd2);
        txn(204, 4'b0111, 32'h0000_0040, 32'h00123456, 2'd2);
        txn(205, 4'b0000, 32'hBFC0_0010, 32'h0, 2'd2);
        txn(206, 4'b0000, 32'h8000_0000, 32'h0, 2'd2);
        txn(207, 4'b0000, 32'h0040_0000, 32'h0, 2'd2);
        txn(208, 4'b1111, 32'hA000_1234, 32'hCAFEF00D, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's M-stage data port: consumes memenM/memwriteM/aluoutM/writedataM and returns readdataM.
- Converts the single-cycle core data request into an SRAM-like req/addr_ok/data_ok bus transaction.
- Asserts stallM to freeze the pipeline while a transaction is outstanding.
- Handles flushM by discarding in-flight results.

Parameters:
- ADDR_W, 32, width of core and bus address.
- DATA_W, 32, data width; fixed at 32 because the byte-write mask is 4 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- memenM  input  1  M-stage memory access enable
- memwriteM  input  4  byte write enables; 0000 means read
- aluoutM  input  32  effective address
- writedataM  input  32  store data, already byte-lane aligned
- flushM  input  1  M stage being flushed (exception/eret)
- readdataM  output  32  load data returned to core, registered
- stallM  output  1  freeze pipeline, combinational
- data_req  output  1  bus request
- data_wr  output  1  1 = write, 0 = read
- data_size  output  2  0 = byte, 1 = half, 2 = word
- data_addr  output  32  bus address
- data_wdata  output  32  bus write data
- data_addr_ok  input  1  slave accepted request
- data_data_ok  input  1  read data valid / write complete
- data_rdata  input  32  bus read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (rst=1 at clk edge, in any state, including mid-transaction): state=IDLE, data_req=0, discard=0, readdataM=0, latched addr/wdata/wr/size=0.
- IDLE: if memenM=1 and flushM=0, latch the request and go to REQ.
  - wr = |memwriteM.
  - size: 1111 or 0000 -> 2; 0011 or 1100 -> 1; one-hot -> 0; any other pattern -> 2.
  - addr = aluoutM, after mapping if the optional feature is enabled.
  - wdata = writedataM.
- REQ: data_req=1, and the address/data outputs hold the latched values. On data_addr_ok=1, go to WAIT. Request is never withdrawn before addr_ok.
- WAIT: data_req=0. On data_data_ok=1:
  - if discard=0: readdataM<=data_rdata (reads only; writes leave readdataM unchanged), go to DONE.
  - if discard=1: go to IDLE, clear discard, readdataM unchanged.
- DONE: exactly one cycle, then IDLE. This releases the stall so the M instruction retires with valid readdataM.
- stallM = (state==REQ) | (state==WAIT) | (state==IDLE & memenM & ~flushM). stallM is 0 in DONE.
- Latency: read with zero-wait slave (addr_ok in first REQ cycle, data_ok next cycle) is 4 cycles from memenM seen in IDLE to DONE. The stall lasts 3 cycles.
- Flush:
  - flushM in IDLE: no request issued.
  - flushM in REQ/WAIT: set discard; the transaction still completes on the bus. Stall remains until it is done.
  - flushM in DONE: no effect, since the data is already latched.
- data_data_ok is ignored outside WAIT. data_addr_ok is ignored outside REQ.
- A new memenM arriving in the cycle after DONE (back-to-back accesses) starts a new transaction from IDLE with no bubble beyond the IDLE cycle.

Optional Feature:
- Macro: DSRAM_ADDR_MAP_EN.
- Defined: kseg0/kseg1 mapping. If aluoutM[31:29] is 3'b100 or 3'b101, data_addr = {3'b000, aluoutM[28:0]}; all other addresses pass unchanged.
- Undefined: data_addr = aluoutM unchanged.

Test Plan:
- Read, addr 0x0000_0100, zero-wait slave returns 0xDEADBEEF -> data_req high 1 cycle, size=2, wr=0; stallM high 3 cycles; readdataM=0xDEADBEEF in DONE.
- Byte store memwriteM=0100, addr 0x0000_0202, writedataM=0x00AB0000 -> data_wr=1, size=0, data_addr=0x202, data_wdata=0x00AB0000; readdataM unchanged.
- Slave delays addr_ok 3 cycles and data_ok 2 more -> data_req held stable 4 cycles; stallM stays high throughout; exactly one DONE cycle.
- flushM pulsed while in WAIT, data_rdata=0x12345678 -> bridge returns to IDLE without DONE; readdataM keeps its old value; next access proceeds normally.
- rst asserted while in REQ -> next cycle data_req=0, stallM reflects IDLE, readdataM=0.
- With DSRAM_ADDR_MAP_EN, read of 0xBFC0_0010 -> data_addr=0x1FC0_0010; 0x8000_0000 -> 0x0000_0000; 0x0040_0000 unchanged.
